// File: rtl/odd_parity_pkg.sv
// Shared types and constants for the odd-parity frame controller.
// Also provides the reference parity rule used by the bench.
package odd_parity_pkg;

    localparam int DEF_DATA_W = 3;
    localparam int DEF_ERR_W  = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DATA = 2'd1,
        PAR  = 2'd2,
        STOP = 2'd3
    } state_t;

    // Odd parity holds when data bits plus parity XOR to 1.
    function automatic logic odd_ok(
        input logic [31:0] data,
        input logic        par
    );
        return (^data) ^ par;
    endfunction

endpackage

// File: rtl/serial_parity_acc.sv
// One-bit serial XOR accumulator.
// clr wins over en; cleared at the start of every frame.
module serial_parity_acc
    import odd_parity_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    input  logic din,
    output logic acc
);

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            acc <= 1'b0;
        end else if (en) begin
            acc <= acc ^ din;
        end
    end

endmodule

// File: rtl/odd_parity_frame_ctrl.sv
// Bit-serial odd-parity frame receiver with a one-word
// valid/ready output, sticky overrun and saturating error count.
module odd_parity_frame_ctrl
    import odd_parity_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ERR_W  = DEF_ERR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              bit_en,
    input  logic              sin,
    input  logic              out_ready,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    output logic              out_par_err,
    output logic              out_frm_err,
    output logic              overrun,
    input  logic              clr_err,
    output logic [ERR_W-1:0]  err_cnt,
    output logic              busy
);

    localparam int CW = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [CW-1:0]    CNT_LAST = CW'(DATA_W - 1);
    localparam logic [ERR_W-1:0] ERR_MAX  = '1;

    state_t            state;
    state_t            state_n;
    logic [CW-1:0]     cnt;
    logic [DATA_W-1:0] shreg;
    logic              acc;
    logic              acc_clr;
    logic              acc_en;
    logic              done;
    logic              par_err;
    logic              frm_err;
    logic              load;

    serial_parity_acc u_acc (
        .clk (clk),
        .rst (rst),
        .clr (acc_clr),
        .en  (acc_en),
        .din (sin),
        .acc (acc)
    );

    always_comb begin
        state_n = state;
        acc_clr = 1'b0;
        acc_en  = 1'b0;
        done    = 1'b0;
        par_err = 1'b0;
        frm_err = 1'b0;
        if (bit_en) begin
            unique case (state)
                IDLE: begin
                    if (!sin) begin
                        state_n = DATA;
                        acc_clr = 1'b1;
                    end
                end
                DATA: begin
                    acc_en = 1'b1;
                    if (cnt == CNT_LAST) begin
                        state_n = PAR;
                    end
                end
                PAR: begin
                    acc_en  = 1'b1;
                    state_n = STOP;
                end
                STOP: begin
                    done    = 1'b1;
                    par_err = ~acc;
                    frm_err = ~sin;
                    state_n = IDLE;
                end
                default: state_n = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
            shreg <= '0;
        end else begin
            state <= state_n;
            if (bit_en && state == IDLE && !sin) begin
                cnt <= '0;
            end else if (bit_en && state == DATA) begin
                shreg[cnt] <= sin;
                cnt        <= cnt + 1'b1;
            end
        end
    end

    // A completed word is taken if the slot is empty or draining now.
    assign load = done && (!out_valid || out_ready);

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid   <= 1'b0;
            out_data    <= '0;
            out_par_err <= 1'b0;
            out_frm_err <= 1'b0;
        end else if (load) begin
            out_valid   <= 1'b1;
            out_data    <= shreg;
            out_par_err <= par_err;
            out_frm_err <= frm_err;
        end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            overrun <= 1'b0;
            err_cnt <= '0;
        end else if (clr_err) begin
            overrun <= 1'b0;
            err_cnt <= '0;
        end else begin
            if (done && !load) begin
                overrun <= 1'b1;
            end
            if (done && (par_err || frm_err) && err_cnt != ERR_MAX) begin
                err_cnt <= err_cnt + 1'b1;
            end
        end
    end

    assign busy = (state != IDLE);

endmodule

// File: tb/tb_odd_parity_frame_ctrl.sv
// Self-checking bench for odd_parity_frame_ctrl (DATA_W=3, ERR_W=8).
module tb_odd_parity_frame_ctrl;
    import odd_parity_pkg::*;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       bit_en = 1'b0;
    logic       sin = 1'b1;
    logic       out_ready = 1'b0;
    logic       clr_err = 1'b0;
    logic       out_valid;
    logic [2:0] out_data;
    logic       out_par_err;
    logic       out_frm_err;
    logic       overrun;
    logic [7:0] err_cnt;
    logic       busy;

    int checks = 0;
    int errors = 0;

    odd_parity_frame_ctrl #(.DATA_W(3), .ERR_W(8)) dut (
        .clk         (clk),
        .rst         (rst),
        .bit_en      (bit_en),
        .sin         (sin),
        .out_ready   (out_ready),
        .out_valid   (out_valid),
        .out_data    (out_data),
        .out_par_err (out_par_err),
        .out_frm_err (out_frm_err),
        .overrun     (overrun),
        .clr_err     (clr_err),
        .err_cnt     (err_cnt),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    task automatic send_bit(input logic b);
        @(negedge clk); bit_en = 1'b1; sin = b;
        @(negedge clk); bit_en = 1'b0; sin = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    // Ends at the negedge right after the stop-bit sampling edge.
    task automatic send_frame(input logic [2:0] d, input logic p,
                              input logic s, input logic rdy_stop,
                              input logic clr_stop);
        send_bit(1'b0);
        for (int i = 0; i < 3; i++) send_bit(d[i]);
        send_bit(p);
        @(negedge clk);
        bit_en = 1'b1; sin = s;
        if (rdy_stop) out_ready = 1'b1;
        if (clr_stop) clr_err = 1'b1;
        @(negedge clk);
        bit_en = 1'b0; sin = 1'b1; clr_err = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if ({out_valid, out_data, out_par_err, out_frm_err, overrun, busy} !== 8'h00) begin
            errors++;
            $display("FAIL reset_outs: got %b want 0", {out_valid, out_data, out_par_err, out_frm_err, overrun, busy});
        end
        checks++;
        if (err_cnt !== 8'd0) begin
            errors++; $display("FAIL reset_cnt: got %0d want 0", err_cnt);
        end
    endtask

    task automatic test_good_frame;
        out_ready = 1'b1;
        send_frame(3'b101, 1'b1, 1'b1, 1'b0, 1'b0);
        checks++;
        if ({out_valid, out_data, out_par_err, out_frm_err} !== 6'b1_101_00) begin
            errors++;
            $display("FAIL good_word: got %b want 110100", {out_valid, out_data, out_par_err, out_frm_err});
        end
        checks++;
        if (err_cnt !== 8'd0) begin
            errors++; $display("FAIL good_cnt: got %0d want 0", err_cnt);
        end
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0) begin
            errors++; $display("FAIL good_one_cycle: got %b want 0", out_valid);
        end
    endtask

    task automatic test_par_err;
        send_frame(3'b011, 1'b0, 1'b1, 1'b0, 1'b0);
        checks++;
        if ({out_valid, out_data, out_par_err, out_frm_err} !== 6'b1_011_10) begin
            errors++;
            $display("FAIL par_word: got %b want 101110", {out_valid, out_data, out_par_err, out_frm_err});
        end
        checks++;
        if (err_cnt !== 8'd1) begin
            errors++; $display("FAIL par_cnt: got %0d want 1", err_cnt);
        end
    endtask

    task automatic test_frm_err;
        send_frame(3'b101, 1'b1, 1'b0, 1'b0, 1'b0);
        checks++;
        if ({out_valid, out_data, out_par_err, out_frm_err} !== 6'b1_101_01) begin
            errors++;
            $display("FAIL frm_word: got %b want 110101", {out_valid, out_data, out_par_err, out_frm_err});
        end
        checks++;
        if (err_cnt !== 8'd2 || busy !== 1'b0) begin
            errors++; $display("FAIL frm_cnt_busy: got %0d/%b want 2/0", err_cnt, busy);
        end
        send_frame(3'b110, 1'b1, 1'b1, 1'b0, 1'b0);
        checks++;
        if ({out_valid, out_data, out_par_err, out_frm_err} !== 6'b1_110_00) begin
            errors++;
            $display("FAIL frm_next: got %b want 111000", {out_valid, out_data, out_par_err, out_frm_err});
        end
    endtask

    task automatic test_backpressure;
        @(negedge clk);
        out_ready = 1'b0;
        send_frame(3'b101, 1'b1, 1'b1, 1'b0, 1'b0);
        send_frame(3'b010, 1'b0, 1'b1, 1'b0, 1'b0);
        repeat (3) @(negedge clk);
        checks++;
        if ({out_valid, out_data, overrun} !== 5'b1_101_1) begin
            errors++;
            $display("FAIL bp_hold: got %b want 11011", {out_valid, out_data, overrun});
        end
        out_ready = 1'b1;
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0 || out_data !== 3'b101) begin
            errors++; $display("FAIL bp_drain: got %b/%b want 0/101", out_valid, out_data);
        end
        clr_err = 1'b1;
        @(negedge clk);
        clr_err = 1'b0;
        checks++;
        if (overrun !== 1'b0 || err_cnt !== 8'd0) begin
            errors++; $display("FAIL bp_clr: got %b/%0d want 0/0", overrun, err_cnt);
        end
    endtask

    task automatic test_simultaneous;
        out_ready = 1'b0;
        send_frame(3'b101, 1'b1, 1'b1, 1'b0, 1'b0);
        send_frame(3'b110, 1'b1, 1'b1, 1'b1, 1'b0);
        checks++;
        if ({out_valid, out_data, overrun} !== 5'b1_110_0) begin
            errors++;
            $display("FAIL sim_load: got %b want 11100", {out_valid, out_data, overrun});
        end
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0) begin
            errors++; $display("FAIL sim_drain: got %b want 0", out_valid);
        end
        send_frame(3'b000, 1'b0, 1'b1, 1'b0, 1'b0);
        checks++;
        if (err_cnt !== 8'd1 || out_par_err !== 1'b1) begin
            errors++; $display("FAIL sim_err1: got %0d/%b want 1/1", err_cnt, out_par_err);
        end
        send_frame(3'b000, 1'b0, 1'b1, 1'b0, 1'b1);
        checks++;
        if (err_cnt !== 8'd0) begin
            errors++; $display("FAIL sim_clr_prio: got %0d want 0", err_cnt);
        end
    endtask

    task automatic test_reset_midframe;
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b0);
        checks++;
        if (busy !== 1'b1) begin
            errors++; $display("FAIL mid_busy: got %b want 1", busy);
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checks++;
        if (busy !== 1'b0 || out_valid !== 1'b0) begin
            errors++; $display("FAIL mid_abort: got %b/%b want 0/0", busy, out_valid);
        end
        repeat (12) @(negedge clk);
        checks++;
        if (out_valid !== 1'b0) begin
            errors++; $display("FAIL mid_noword: got %b want 0", out_valid);
        end
        send_frame(3'b011, 1'b1, 1'b1, 1'b0, 1'b0);
        checks++;
        if ({out_valid, out_data, out_par_err, out_frm_err} !== 6'b1_011_00) begin
            errors++;
            $display("FAIL mid_next: got %b want 101100", {out_valid, out_data, out_par_err, out_frm_err});
        end
        @(negedge clk);
    endtask

    // Transaction-level model: one-word slot, drop-and-flag on overrun.
    task automatic test_random;
        logic       pend = 1'b0;
        logic [2:0] pd = '0;
        logic       ppe = 1'b0;
        logic       pfe = 1'b0;
        logic       ovr = 1'b0;
        int         cnt = 0;
        logic [2:0] d;
        logic       p, s, pe, fe;
        out_ready = 1'b0;
        clr_err = 1'b1;
        @(negedge clk);
        clr_err = 1'b0;
        for (int n = 0; n < 16; n++) begin
            d = 3'($urandom);
            p = 1'($urandom);
            s = ($urandom % 4) != 0;
            pe = !odd_ok({29'b0, d}, p);
            fe = !s;
            send_frame(d, p, s, 1'b0, 1'b0);
            if ((pe || fe) && cnt < 255) cnt++;
            if (pend) begin
                ovr = 1'b1;
            end else begin
                pend = 1'b1; pd = d; ppe = pe; pfe = fe;
            end
            checks++;
            if (out_valid !== pend || overrun !== ovr || err_cnt !== 8'(cnt)) begin
                errors++;
                $display("FAIL rnd_status[%0d]: got %b/%b/%0d want %b/%b/%0d",
                         n, out_valid, overrun, err_cnt, pend, ovr, cnt);
            end
            checks++;
            if (pend && {out_data, out_par_err, out_frm_err} !== {pd, ppe, pfe}) begin
                errors++;
                $display("FAIL rnd_word[%0d]: got %b want %b", n,
                         {out_data, out_par_err, out_frm_err}, {pd, ppe, pfe});
            end
            if ($urandom % 2 == 1) begin
                out_ready = 1'b1;
                @(negedge clk);
                out_ready = 1'b0;
                pend = 1'b0;
                checks++;
                if (out_valid !== 1'b0) begin
                    errors++; $display("FAIL rnd_drain[%0d]: got %b want 0", n, out_valid);
                end
            end
        end
    endtask

    task automatic test_saturation;
        out_ready = 1'b1;
        clr_err = 1'b1;
        @(negedge clk);
        clr_err = 1'b0;
        for (int i = 1; i <= 260; i++) begin
            send_frame(3'b000, 1'b0, 1'b1, 1'b0, 1'b0);
            if (i == 100 || i == 255 || i == 260) begin
                checks++;
                if (err_cnt !== 8'((i > 255) ? 255 : i)) begin
                    errors++;
                    $display("FAIL sat_cnt[%0d]: got %0d want %0d", i, err_cnt, (i > 255) ? 255 : i);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_good_frame();
        test_par_err();
        test_frm_err();
        test_backpressure();
        test_simultaneous();
        test_reset_midframe();
        test_random();
        test_saturation();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
